// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge
//   Registered Wishbone bridge from the management-side port (wbs_*) to a
//   peripheral slave port (p_*). In-window cycles are forwarded, and an abort
//   is issued if the peripheral does not acknowledge within TIMEOUT_CYCLES.
//   Out-of-window cycles are answered locally with ERR_DATA.
//
// Ports
//   wb_clk_i, wb_rst_ni       clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i      upstream cycle, strobe, write enable
//   wbs_sel_i/adr_i/dat_i     upstream byte selects, address, write data
//   wbs_ack_o, wbs_dat_o      upstream registered ack and read data
//   p_cyc_o/stb_o/we_o        downstream cycle, strobe, write enable
//   p_sel_o/adr_o/dat_o       downstream byte selects, address, write data
//   p_ack_i, p_dat_i          downstream ack and read data
//   to_irq_o                  one-cycle pulse on timeout abort
//   dec_err_o                 one-cycle pulse on out-of-window access
//   to_count_o                saturating timeout count
module wb_timeout_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        p_cyc_o,
    output logic        p_stb_o,
    output logic        p_we_o,
    output logic [3:0]  p_sel_o,
    output logic [31:0] p_adr_o,
    output logic [31:0] p_dat_o,
    input  logic        p_ack_i,
    input  logic [31:0] p_dat_i,
    output logic        to_irq_o,
    output logic        dec_err_o,
    output logic [7:0]  to_count_o
);

    typedef enum logic [1:0] {StIdle, StFwd, StErr, StDone} state_e;

    // Counter value seen on the last permitted FWD cycle.
    localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 p_cyc_q, p_cyc_d;
    logic                 p_we_q, p_we_d;
    logic [3:0]           p_sel_q, p_sel_d;
    logic [31:0]          p_adr_q, p_adr_d;
    logic [31:0]          p_dat_q, p_dat_d;
    logic                 ack_q, ack_d;
    logic [31:0]          rdat_q, rdat_d;
    logic                 irq_q, irq_d;
    logic                 dec_q, dec_d;
    logic [7:0]           to_cnt_q, to_cnt_d;
    logic                 req;
    logic                 hit;

    assign req = wbs_cyc_i & wbs_stb_i;
    assign hit = ((wbs_adr_i ^ BASE_ADDR) & ADDR_MASK) == 32'h0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_cyc_d  = p_cyc_q;
        p_we_d   = p_we_q;
        p_sel_d  = p_sel_q;
        p_adr_d  = p_adr_q;
        p_dat_d  = p_dat_q;
        to_cnt_d = to_cnt_q;
        // Single-cycle outputs: low unless the transition below raises them.
        ack_d    = 1'b0;
        rdat_d   = 32'h0;
        irq_d    = 1'b0;
        dec_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (req && hit) begin
                    p_adr_d = wbs_adr_i;
                    p_dat_d = wbs_dat_i;
                    p_sel_d = wbs_sel_i;
                    p_we_d  = wbs_we_i;
                    p_cyc_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StFwd;
                end else if (req) begin
                    // Decode error: never touches the peripheral port.
                    dec_d   = 1'b1;
                    state_d = StErr;
                end
            end
            StFwd: begin
                cnt_d = cnt_q + 1'b1;
                // Ack has priority over a timeout in the same cycle.
                if (p_ack_i) begin
                    p_cyc_d = 1'b0;
                    ack_d   = 1'b1;
                    rdat_d  = p_dat_i;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    p_cyc_d = 1'b0;
                    ack_d   = 1'b1;
                    rdat_d  = ERR_DATA;
                    irq_d   = 1'b1;
                    if (to_cnt_q != 8'hFF) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                    state_d = StDone;
                end
            end
            StErr: begin
                ack_d   = 1'b1;
                rdat_d  = ERR_DATA;
                state_d = StDone;
            end
            StDone: begin
                // Ack is being presented this cycle; the master drops stb next.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p_cyc_q  <= 1'b0;
            p_we_q   <= 1'b0;
            p_sel_q  <= 4'h0;
            p_adr_q  <= 32'h0;
            p_dat_q  <= 32'h0;
            ack_q    <= 1'b0;
            rdat_q   <= 32'h0;
            irq_q    <= 1'b0;
            dec_q    <= 1'b0;
            to_cnt_q <= 8'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_cyc_q  <= p_cyc_d;
            p_we_q   <= p_we_d;
            p_sel_q  <= p_sel_d;
            p_adr_q  <= p_adr_d;
            p_dat_q  <= p_dat_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            irq_q    <= irq_d;
            dec_q    <= dec_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdat_q;
    assign p_cyc_o    = p_cyc_q;
    assign p_stb_o    = p_cyc_q;
    assign p_we_o     = p_we_q;
    assign p_sel_o    = p_sel_q;
    assign p_adr_o    = p_adr_q;
    assign p_dat_o    = p_dat_q;
    assign to_irq_o   = irq_q;
    assign dec_err_o  = dec_q;
    assign to_count_o = to_cnt_q;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed + randomized bench for wb_timeout_bridge. Expected behaviour is
// derived per transaction from the window/latency rules: a hit acked at
// request edge + n answers in cycle n+1, a miss answers in cycle 2, and a
// silent peripheral is aborted and answered in cycle T+1 with ERR_DATA.
module tb_wb_timeout_bridge;

    localparam logic [31:0] Base = 32'h3000_0000;
    localparam logic [31:0] Mask = 32'hFFFF_0000;
    localparam int          T    = 255;
    localparam logic [31:0] Err  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        p_cyc, p_stb, p_we;
    logic [3:0]  p_sel;
    logic [31:0] p_adr, p_dat;
    logic        p_ack;
    logic [31:0] p_rdat;
    logic        to_irq, dec_err;
    logic [7:0]  to_count;

    int errors = 0;
    int checks = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    wb_timeout_bridge #(
        .BASE_ADDR     (Base),
        .ADDR_MASK     (Mask),
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_W     (8),
        .ERR_DATA      (Err)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .p_cyc_o   (p_cyc),
        .p_stb_o   (p_stb),
        .p_we_o    (p_we),
        .p_sel_o   (p_sel),
        .p_adr_o   (p_adr),
        .p_dat_o   (p_dat),
        .p_ack_i   (p_ack),
        .p_dat_i   (p_rdat),
        .to_irq_o  (to_irq),
        .dec_err_o (dec_err),
        .to_count_o(to_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One upstream transaction. ack_n: edge (after the request edge) at which
    // the peripheral acks; 0 or anything beyond T means it never acks in time.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input int ack_n, input logic [31:0] pd,
                           input string tag);
        bit          in_win;
        bit          timeout;
        int          lat;
        logic [31:0] exp_dat;
        in_win  = ((a ^ Base) & Mask) == 32'h0;
        timeout = in_win && !(ack_n >= 1 && ack_n <= T);
        if (!in_win)     begin lat = 1;     exp_dat = Err; end
        else if (timeout) begin lat = T;     exp_dat = Err; end
        else             begin lat = ack_n; exp_dat = pd;  end
        if (timeout && model_count < 255) model_count++;

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = s;
        p_ack = 1'b0; p_rdat = pd;
        @(posedge clk);
        for (int c = 1; c <= lat + 2; c++) begin
            @(negedge clk);
            p_ack = (ack_n == c);
            if (c == lat + 2) begin cyc = 1'b0; stb = 1'b0; end
            if (c == 1 && in_win) begin
                chk({tag, ":p_adr"}, p_adr, a);
                chk({tag, ":p_dat"}, p_dat, d);
                chk({tag, ":p_sel"}, {28'h0, p_sel}, {28'h0, s});
                chk({tag, ":p_we"}, {31'h0, p_we}, {31'h0, w});
            end
            chk({tag, ":p_cyc"}, {31'h0, p_cyc}, {31'h0, in_win && c <= lat});
            chk({tag, ":p_stb"}, {31'h0, p_stb}, {31'h0, in_win && c <= lat});
            chk({tag, ":ack"}, {31'h0, ack}, {31'h0, c == lat + 1});
            chk({tag, ":dec_err"}, {31'h0, dec_err}, {31'h0, !in_win && c == 1});
            chk({tag, ":to_irq"}, {31'h0, to_irq}, {31'h0, timeout && c == lat + 1});
            if (c != lat + 1) chk({tag, ":dat_idle"}, rdat, 32'h0);
            else if (!(in_win && !timeout && w)) chk({tag, ":dat"}, rdat, exp_dat);
        end
        p_ack = 1'b0;
        chk({tag, ":to_count"}, {24'h0, to_count}, model_count[31:0]);
    endtask

    initial begin
        logic [31:0] ra;
        int          rn;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; p_ack = 1'b0; p_rdat = 32'h0;
        #12;
        chk("rst:ack", {31'h0, ack}, 32'h0);
        chk("rst:dat", rdat, 32'h0);
        chk("rst:p_cyc", {31'h0, p_cyc}, 32'h0);
        chk("rst:p_adr", p_adr, 32'h0);
        chk("rst:p_dat", p_dat, 32'h0);
        chk("rst:count", {24'h0, to_count}, 32'h0);
        chk("rst:irq_dec", {30'h0, to_irq, dec_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(32'h3000_0004, 1'b1, 32'h1234_5678, 4'hF, 2, 32'h0BAD_0000, "wr");
        run_txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, 1, 32'hA5A5_0001, "rd");
        run_txn(32'h2000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h1111_2222, "miss");
        run_txn(32'h2FFF_FFFC, 1'b1, 32'h5555_AAAA, 4'h3, 1, 32'h0, "miss_wr");
        run_txn(32'h3000_0020, 1'b0, 32'h0, 4'hF, 0, 32'h7777_7777, "to1");
        run_txn(32'h3000_0024, 1'b0, 32'h0, 4'hF, T, 32'hCAFE_F00D, "ack_last");
        run_txn(32'h3000_0028, 1'b0, 32'h0, 4'hF, T + 1, 32'h0, "ack_late");
        run_txn(32'h3000_FFFC, 1'b0, 32'h0, 4'h1, 3, 32'h0123_4567, "edge_hi");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) != 0) ra = {16'h3000, ra[15:0]};
            rn = $urandom_range(1, 6);
            run_txn(ra, 1'($urandom), $urandom, 4'($urandom), rn, $urandom, "rand");
        end

        // Drive the count into saturation.
        for (int i = 0; i < 256; i++) begin
            run_txn({16'h3000, 16'($urandom)}, 1'b0, 32'h0, 4'hF, 0, $urandom, "sat");
        end
        chk("sat:final", {24'h0, to_count}, 32'd255);

        // Reset in the middle of a forwarded cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0040; we = 1'b0; wdat = 32'h0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("mid:p_cyc_before", {31'h0, p_cyc}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid:p_cyc", {31'h0, p_cyc}, 32'h0);
        chk("mid:p_stb", {31'h0, p_stb}, 32'h0);
        chk("mid:ack", {31'h0, ack}, 32'h0);
        chk("mid:count", {24'h0, to_count}, 32'h0);
        model_count = 0;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h3000_0044, 1'b1, 32'hFEED_0001, 4'hC, 2, 32'h0, "post_rst");
        run_txn(32'h3000_0048, 1'b0, 32'h0, 4'hF, 4, 32'h4242_4242, "post_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
